// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared fetch FSM states and word stride
package riscv_fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORT} fetch_state_e;
  localparam logic [31:0] FETCH_STRIDE = 32'd4;
endpackage

// File: rtl/riscv_fetch_req_ctrl.sv
// riscv_fetch_req_ctrl: one-outstanding instruction fetch requester feeding the fetch FIFO
module riscv_fetch_req_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_branch_i,
  input  logic [31:0] hwlp_target_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        fifo_ready_i,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_clear_o,
  output logic        fifo_replace2_o,
  output logic        fifo_is_hwlp_o,
  output logic        busy_o
);
  fetch_state_e state, state_nxt;
  logic [31:0] fetch_addr, out_addr, hwlp_tgt, req_addr, sel_addr;
  logic hwlp_pend, hwlp_out, req_hwlp, sel_hwlp, rv_done, issue, gnt_acc;
  always_comb begin
    rv_done = instr_rvalid_i && (state == WAIT_RVALID || state == WAIT_ABORT);
    issue = req_i && fifo_ready_i && (state == IDLE || rv_done);
    instr_req_o = state == WAIT_GNT || issue;
    gnt_acc = instr_req_o && instr_gnt_i;
    sel_addr = branch_i ? branch_addr_i : state == WAIT_GNT ? req_addr : hwlp_pend ? hwlp_tgt : fetch_addr;
    sel_hwlp = !branch_i && (state == WAIT_GNT ? req_hwlp : hwlp_pend);
    instr_addr_o = {sel_addr[31:2], 2'b00};
    fifo_valid_o = state == WAIT_RVALID && instr_rvalid_i && !branch_i;
    fifo_addr_o = out_addr;
    fifo_rdata_o = instr_rdata_i;
    fifo_clear_o = branch_i;
    fifo_replace2_o = fifo_valid_o && hwlp_out;
    fifo_is_hwlp_o = fifo_valid_o && hwlp_out;
    busy_o = state != IDLE;
    state_nxt = instr_req_o ? (instr_gnt_i ? WAIT_RVALID : WAIT_GNT) :
                rv_done ? IDLE :
                (state == WAIT_RVALID && branch_i) ? WAIT_ABORT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_addr <= RESET_ADDR;
      out_addr <= 32'h0;
      req_addr <= 32'h0;
      req_hwlp <= 1'b0;
      hwlp_pend <= 1'b0;
      hwlp_out <= 1'b0;
      hwlp_tgt <= 32'h0;
    end else begin
      state <= state_nxt;
      if (gnt_acc) begin
        out_addr <= sel_addr;
        hwlp_out <= sel_hwlp;
        fetch_addr <= {sel_addr[31:2], 2'b00} + FETCH_STRIDE;
      end else if (branch_i) begin
        fetch_addr <= branch_addr_i;
      end
      if (instr_req_o && !instr_gnt_i) begin
        req_addr <= sel_addr;
        req_hwlp <= sel_hwlp;
      end
      hwlp_pend <= branch_i ? 1'b0 : hwlp_branch_i ? 1'b1 : (gnt_acc && sel_hwlp) ? 1'b0 : hwlp_pend;
      if (hwlp_branch_i && !branch_i) hwlp_tgt <= hwlp_target_i;
    end
  end
endmodule

// File: tb/tb_riscv_fetch_req_ctrl.sv
// tb_riscv_fetch_req_ctrl: directed self-checking bench for the fetch request controller
module tb_riscv_fetch_req_ctrl;
  logic clk = 1'b0, rst, req_i, branch_i, hwlp_branch_i, instr_gnt_i, instr_rvalid_i, fifo_ready_i;
  logic [31:0] branch_addr_i, hwlp_target_i, instr_rdata_i;
  logic instr_req_o, fifo_valid_o, fifo_clear_o, fifo_replace2_o, fifo_is_hwlp_o, busy_o;
  logic [31:0] instr_addr_o, fifo_addr_o, fifo_rdata_o;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  riscv_fetch_req_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .hwlp_branch_i(hwlp_branch_i), .hwlp_target_i(hwlp_target_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .fifo_ready_i(fifo_ready_i),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_clear_o(fifo_clear_o), .fifo_replace2_o(fifo_replace2_o), .fifo_is_hwlp_o(fifo_is_hwlp_o),
    .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; req_i = 0; branch_i = 0; branch_addr_i = 0; hwlp_branch_i = 0; hwlp_target_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; fifo_ready_i = 1;
    cyc(); cyc();
    rst = 0;
    #2;
    chk("rst_req", 32'(instr_req_o), 0);
    chk("rst_valid", 32'(fifo_valid_o), 0);
    chk("rst_clear", 32'(fifo_clear_o), 0);
    chk("rst_rep2", 32'(fifo_replace2_o), 0);
    chk("rst_hwlp", 32'(fifo_is_hwlp_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    cyc(); req_i = 1; #2;
    chk("a_req", 32'(instr_req_o), 1);
    chk("a_addr", instr_addr_o, 32'h0);
    cyc(); instr_gnt_i = 1; #2;
    chk("b_busy", 32'(busy_o), 1);
    chk("b_addr", instr_addr_o, 32'h0);
    cyc(); instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hA000_0000; #2;
    chk("c_valid", 32'(fifo_valid_o), 1);
    chk("c_faddr", fifo_addr_o, 32'h0);
    chk("c_rdata", fifo_rdata_o, 32'hA000_0000);
    chk("c_addr", instr_addr_o, 32'h4);
    cyc(); instr_rvalid_i = 0; instr_gnt_i = 1; #2;
    chk("d_valid", 32'(fifo_valid_o), 0);
    chk("d_addr", instr_addr_o, 32'h4);
    cyc(); instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hA000_0004; #2;
    chk("e_faddr", fifo_addr_o, 32'h4);
    chk("e_addr", instr_addr_o, 32'h8);
    cyc(); instr_rvalid_i = 0; instr_gnt_i = 1; #2;
    chk("f_addr", instr_addr_o, 32'h8);
    cyc(); instr_rvalid_i = 1; instr_gnt_i = 1; #2;
    chk("g_faddr", fifo_addr_o, 32'h8);
    chk("g_addr", instr_addr_o, 32'hC);
    cyc(); #2;
    chk("h_valid", 32'(fifo_valid_o), 1);
    chk("h_faddr", fifo_addr_o, 32'hC);
    chk("h_addr", instr_addr_o, 32'h10);
    cyc(); instr_rvalid_i = 0; instr_gnt_i = 0; branch_i = 1; branch_addr_i = 32'h0000_1006; #2;
    chk("i_clear", 32'(fifo_clear_o), 1);
    chk("i_valid", 32'(fifo_valid_o), 0);
    chk("i_req", 32'(instr_req_o), 0);
    cyc(); branch_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hDEAD_BEEF; #2;
    chk("j_drop", 32'(fifo_valid_o), 0);
    chk("j_req", 32'(instr_req_o), 1);
    chk("j_addr", instr_addr_o, 32'h1004);
    cyc(); instr_rvalid_i = 0; instr_gnt_i = 1; #2;
    chk("k_addr", instr_addr_o, 32'h1004);
    cyc(); instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h5555_5555; #2;
    chk("l_valid", 32'(fifo_valid_o), 1);
    chk("l_faddr", fifo_addr_o, 32'h1006);
    chk("l_addr", instr_addr_o, 32'h1008);
    cyc(); instr_rvalid_i = 0; instr_gnt_i = 1; branch_i = 1; branch_addr_i = 32'h40; #2;
    chk("m_clear", 32'(fifo_clear_o), 1);
    chk("m_addr", instr_addr_o, 32'h40);
    cyc(); instr_gnt_i = 0; branch_i = 0; hwlp_branch_i = 1; hwlp_target_i = 32'h200; #2;
    chk("n_clear", 32'(fifo_clear_o), 0);
    chk("n_valid", 32'(fifo_valid_o), 0);
    cyc(); hwlp_branch_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h0000_4040; #2;
    chk("o_faddr", fifo_addr_o, 32'h40);
    chk("o_rep2", 32'(fifo_replace2_o), 0);
    chk("o_hwlp", 32'(fifo_is_hwlp_o), 0);
    chk("o_addr", instr_addr_o, 32'h200);
    cyc(); instr_rvalid_i = 0; instr_gnt_i = 1; #2;
    chk("p_addr", instr_addr_o, 32'h200);
    cyc(); instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h0000_0200; #2;
    chk("q_faddr", fifo_addr_o, 32'h200);
    chk("q_rep2", 32'(fifo_replace2_o), 1);
    chk("q_hwlp", 32'(fifo_is_hwlp_o), 1);
    chk("q_addr", instr_addr_o, 32'h204);
    cyc(); instr_rvalid_i = 0; instr_gnt_i = 1; #2;
    chk("r_addr", instr_addr_o, 32'h204);
    cyc(); instr_gnt_i = 0; fifo_ready_i = 0; instr_rvalid_i = 1; #2;
    chk("s_valid", 32'(fifo_valid_o), 1);
    chk("s_faddr", fifo_addr_o, 32'h204);
    chk("s_rep2", 32'(fifo_replace2_o), 0);
    chk("s_req", 32'(instr_req_o), 0);
    cyc(); instr_rvalid_i = 0; #2;
    chk("t_req", 32'(instr_req_o), 0);
    chk("t_busy", 32'(busy_o), 0);
    cyc(); fifo_ready_i = 1; branch_i = 1; branch_addr_i = 32'hFFFF_FFFC; instr_gnt_i = 1; #2;
    chk("u_addr", instr_addr_o, 32'hFFFF_FFFC);
    cyc(); branch_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1; #2;
    chk("v_faddr", fifo_addr_o, 32'hFFFF_FFFC);
    chk("v_wrap", instr_addr_o, 32'h0);
    cyc(); instr_rvalid_i = 0; rst = 1; #2;
    chk("w_req", 32'(instr_req_o), 1);
    cyc(); rst = 0; req_i = 0; instr_rvalid_i = 1; #2;
    chk("x_req", 32'(instr_req_o), 0);
    chk("x_valid", 32'(fifo_valid_o), 0);
    chk("x_busy", 32'(busy_o), 0);
    cyc(); instr_rvalid_i = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/riscv_fetch_req_ctrl.md
# riscv_fetch_req_ctrl

Instruction-fetch request controller between the core's instruction memory port and `riscv_fetch_fifo`. It issues word-aligned fetch requests under a req/gnt/rvalid handshake with one outstanding transaction. It forwards returned words with their addresses into the FIFO and handles branch redirects, aborting any in-flight request. It also retargets fetch for hardware-loop jumps and tags those words so the FIFO replaces its second entry.

## Interface
- `RESET_ADDR`, 32'h0000_0000: fetch address after reset (word-aligned).
- `clk  in  1`  clock; all state updates on the rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `req_i  in  1`  fetch enable from the controller.
- `branch_i  in  1`  redirect; takes priority over every other event.
- `branch_addr_i  in  32`  redirect target; bits [1:0] are ignored for the request.
- `hwlp_branch_i  in  1`  hardware-loop jump request.
- `hwlp_target_i  in  32`  hardware-loop target.
- `instr_req_o  out  1`  memory request.
- `instr_addr_o  out  32`  request address, always with [1:0] = 00.
- `instr_gnt_i  in  1`  request accepted.
- `instr_rvalid_i  in  1`  read data valid.
- `instr_rdata_i  in  32`  read data.
- `fifo_ready_i  in  1`  FIFO has room (its `in_ready_o`).
- `fifo_valid_o  out  1`  word valid toward the FIFO.
- `fifo_addr_o  out  32`  address of the word; [1] is preserved for branch targets.
- `fifo_rdata_o  out  32`  word data.
- `fifo_clear_o  out  1`  flushes the FIFO.
- `fifo_replace2_o  out  1`  tells the FIFO to replace its second entry.
- `fifo_is_hwlp_o  out  1`  marks the word as a hardware-loop target.
- `busy_o  out  1`  a transaction is pending or outstanding.

## Operation
- States:
  - IDLE: no request.
  - WAIT_GNT: `instr_req_o` high, waiting for grant.
  - WAIT_RVALID: one request granted, data pending.
  - WAIT_ABORT: a granted request is stale; its data will be discarded.
- Registers:
  - `fetch_addr`: 32 bit. Next request is `{fetch_addr[31:2],2'b00}`.
  - `out_addr`: 32 bit. Address tagged on the outstanding word.
  - `hwlp_pend`, `hwlp_out`, `hwlp_tgt`.
- Issue condition: `req_i && fifo_ready_i` while in IDLE, or on rvalid while in WAIT_RVALID/WAIT_ABORT. A request is held (`instr_req_o=1`, address stable) until `instr_gnt_i`. Exception: `branch_i` in WAIT_GNT switches the address to the new target.
- On grant:
  - `out_addr <= fetch_addr`.
  - `fetch_addr <= {fetch_addr[31:2],2'b00} + 4`. The add wraps modulo 2^32.
  - Next state is WAIT_RVALID.
- In WAIT_RVALID, on `instr_rvalid_i`:
  - Drive `fifo_valid_o=1`, `fifo_addr_o=out_addr`, `fifo_rdata_o=instr_rdata_i`.
  - Drive `fifo_replace2_o` and `fifo_is_hwlp_o` from `hwlp_out`.
  - Next state: WAIT_GNT if issuing again, otherwise IDLE.
- `branch_i`:
  - `fifo_clear_o=1` in the same cycle.
  - `fetch_addr <= branch_addr_i`; `hwlp_pend` is cleared.
  - If in WAIT_RVALID, go to WAIT_ABORT.
  - In WAIT_ABORT, the returning rvalid is dropped (`fifo_valid_o=0`).
- `hwlp_branch_i` (when `branch_i` is low):
  - `hwlp_pend <= 1`, `hwlp_tgt <= hwlp_target_i`. The FIFO is not cleared.
  - An already-outstanding word is still delivered untagged.
  - At the next issue, the address is `hwlp_tgt` instead of `fetch_addr`. That grant sets `hwlp_out=1`, clears `hwlp_pend`, and sets `fetch_addr = hwlp_tgt[31:2]*4 + 4`.
- `fifo_valid_o` is never asserted in IDLE, WAIT_GNT or WAIT_ABORT. Exception: WAIT_GNT entered from WAIT_RVALID in the rvalid cycle itself.
- `busy_o = (state != IDLE)`.

## Timing
- Reset values:
  - `instr_req_o=0`, `fifo_valid_o=0`, `fifo_clear_o=0`, `fifo_replace2_o=0`, `fifo_is_hwlp_o=0`, `busy_o=0`.
  - State IDLE, `fetch_addr=RESET_ADDR`, hwlp registers 0.
- `rst` mid-transaction returns to IDLE next cycle. A late rvalid arriving in IDLE is ignored.
- Request-to-FIFO latency: grant at cycle g, rvalid at cycle r ≥ g+1, `fifo_valid_o` at r (combinational pass-through).
- Throughput: one word per cycle when gnt and rvalid are both single-cycle.
- `branch_i` together with `instr_rvalid_i` in WAIT_RVALID: the word is dropped, the FIFO is cleared, and the new request issues in that same cycle if `req_i` is high.
- `branch_i` together with `instr_gnt_i` in WAIT_GNT: the grant applies to the new target address.
- `fifo_ready_i` low: no new request issues. The already-outstanding word is still pushed, because the FIFO reserves one slot.
- `req_i` deasserted: the outstanding transaction completes, then the block returns to IDLE.

## Structure
- Shared package `riscv_fetch_pkg`: FSM enum `fetch_state_e` (IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORT) and the word stride constant `FETCH_STRIDE=4`.
- Single module, no sub-modules. The FSM and address registers are small enough to stay flat.
- Instantiated next to `riscv_fetch_fifo` inside the prefetch buffer wrapper.

## Test plan
- Reset, `req_i=1`, gnt/rvalid each 1 cycle after the request -> `instr_addr_o` 0x0, 0x4, 0x8; `fifo_valid_o` pulses carry matching `fifo_addr_o`.
- `branch_i` to 0x0000_1006 while in WAIT_RVALID for 0x10 -> `fifo_clear_o` pulses; the rvalid for 0x10 is dropped; the next request is 0x1004 and its word is pushed with `fifo_addr_o=0x1006`.
- `hwlp_branch_i` with target 0x200 while 0x40 is outstanding -> the 0x40 word is pushed untagged; the next request is 0x200, pushed with `fifo_replace2_o=1` and `fifo_is_hwlp_o=1`; the following request is 0x204.
- `fifo_ready_i=0` during WAIT_RVALID -> the word is pushed, then `instr_req_o` stays 0 until ready returns.
- `fetch_addr=0xFFFF_FFFC` granted -> the next request is 0x0000_0000 (wrap).
- `rst` asserted in WAIT_GNT -> `instr_req_o=0` next cycle; a stray rvalid produces no push.
